// File: rtl/bcd_seq_ctrl.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3, 14 shift cycles).
// Optional build macro BCD_SATURATE_EN: clamp bcd_out to 16'h9999 when the value exceeds 9999.
module bcd_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] sr_q, sr_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  logic [19:0] acc_adj;
  logic [33:0] shifted;
  logic [19:0] acc_sh;
  logic [13:0] sr_sh;
  logic        ovf_final;
  logic [15:0] bcd_final;

  // Add-3 correction on every digit before the shift, so no nibble passes 9 after doubling.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? (acc_q[gi*4 +: 4] + 4'd3)
                                                             : acc_q[gi*4 +: 4];
    end
  endgenerate

  assign shifted   = {acc_adj, sr_q} << 1;
  assign acc_sh    = shifted[33:14];
  assign sr_sh     = shifted[13:0];
  assign ovf_final = (acc_sh[19:16] != 4'd0);

`ifdef BCD_SATURATE_EN
  assign bcd_final = ovf_final ? 16'h9999 : acc_sh[15:0];
`else
  assign bcd_final = acc_sh[15:0];
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sr_d    = bin_in;
          acc_d   = 20'd0;
          cnt_d   = 4'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = acc_sh;
        sr_d  = sr_sh;
        cnt_d = cnt_q + 4'd1;
        // Counter value 13 marks the edge performing the 14th and final shift.
        if (cnt_q == 4'd13) begin
          state_d = DONE;
          bcd_d   = bcd_final;
          ovf_d   = ovf_final;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= 14'd0;
      acc_q   <= 20'd0;
      cnt_q   <= 4'd0;
      bcd_q   <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: a queue of expected results is pushed on each request
// and popped when done pulses. Honours BCD_SATURATE_EN the same way as the design.
module tb_bcd_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  bcd_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int v);
    exp_t e;
    int   lo;
    lo    = v % 10000;
    e.ovf = (v > 9999);
    e.bcd = {4'((lo / 1000) % 10), 4'((lo / 100) % 10), 4'((lo / 10) % 10), 4'(lo % 10)};
`ifdef BCD_SATURATE_EN
    if (e.ovf) e.bcd = 16'h9999;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one request for a single edge; the caller knows it will be accepted.
  task automatic issue(input int v);
    start  = 1'b1;
    bin_in = 14'(v);
    q.push_back(model(v));
    tick();
    start  = 1'b0;
    bin_in = 14'($urandom);
  endtask

  task automatic wait_done(input int k0, output int lat);
    lat = k0;
    while (done !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, {31'd0, (q.size() > 0)}, 32'd1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check({tag, "_bcd"}, {16'd0, bcd_out}, {16'd0, e.bcd});
      check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
      $display("result %s: bcd_out=%04h overflow=%0b", tag, bcd_out, overflow);
    end
  endtask

  initial begin
    int lat;
    int k;
    int busy_cnt;
    int done_cnt;

    rst = 1'b1; start = 1'b0; bin_in = 14'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {16'd0, bcd_out}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    tick();

    // 1000: latency, busy width, single done pulse
    issue(1000);
    busy_cnt = 0; k = 0;
    while (done !== 1'b1 && k < 60) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      k++;
    end
    check("t1000_latency", k, 14);
    check("t1000_busy_cycles", busy_cnt, 14);
    check("t1000_busy_in_done", {31'd0, busy}, 32'd0);
    compare_result("t1000");
    tick();
    check("t1000_done_low", {31'd0, done}, 32'd0);

    // Boundary values
    issue(0);
    wait_done(0, lat);
    compare_result("t0");
    tick();
    issue(9999);
    wait_done(0, lat);
    compare_result("t9999");
    tick();
    issue(16383);
    wait_done(0, lat);
    compare_result("t16383");
    tick();
    issue(10000);
    wait_done(0, lat);
    compare_result("t10000");
    tick();

    // Start while busy is ignored; bin_in changes during SHIFT are ignored
    issue(1234);
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; bin_in = 14'd42;
    tick();
    start = 1'b0; bin_in = 14'd777;
    check("t1234_bcd_hold", {16'd0, bcd_out}, {16'd0, model(10000).bcd});
    wait_done(5, lat);
    check("t1234_latency", lat, 14);
    compare_result("t1234");
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    check("t1234_extra_done", done_cnt, 0);
    check("t1234_idle_busy", {31'd0, busy}, 32'd0);

    // Reset mid-conversion aborts with no done pulse
    issue(4321);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    void'(q.pop_back());
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_bcd", {16'd0, bcd_out}, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    issue(56);
    wait_done(0, lat);
    compare_result("t0056");
    tick();

    // Back-to-back: start held high, second request accepted in the DONE cycle
    start = 1'b1; bin_in = 14'd12;
    q.push_back(model(12));
    tick();
    bin_in = 14'd345;
    q.push_back(model(345));
    wait_done(0, lat);
    check("b2b_first_latency", lat, 14);
    compare_result("t0012");
    tick();
    start = 1'b0;
    check("b2b_second_busy", {31'd0, busy}, 32'd1);
    wait_done(1, lat);
    check("b2b_done_spacing", lat, 15);
    compare_result("t0345");
    tick();
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("sb_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_seq_ctrl.md
BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 Parameters: none; the binary width is fixed at 14 bits and the BCD width at 4 digits (16 bits).
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  conversion request, sampled on the rising edge of clk.
REQ-005 bin_in  input  14  unsigned binary value (0..16383), sampled only on the edge that accepts start.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking a completed conversion.
REQ-008 bcd_out  output  16  four packed BCD digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-009 overflow  output  1  high when the last accepted bin_in was greater than 9999.

Function
REQ-010 The block SHALL implement the FSM IDLE -> SHIFT -> DONE -> IDLE as a sequential shift-add-3 (double-dabble) converter.
REQ-011 Acceptance: start=1 while busy=0 (IDLE or DONE) SHALL, at edge N, load bin_in into the shift register, clear the 20-bit (5-digit) BCD accumulator, clear the iteration counter, and enter SHIFT.
REQ-012 SHIFT: on each edge, every BCD nibble >= 5 SHALL be incremented by 3, then {accumulator, shift register} SHALL shift left by 1.
REQ-013 The counter SHALL count exactly 14 shift edges, N+1..N+14; the edge that performs the 14th shift SHALL enter DONE.
REQ-014 The 14th-shift edge SHALL register bcd_out and overflow from the final accumulator value.
REQ-015 done SHALL be 1 for exactly the one cycle following edge N+14 (state DONE), then 0.
REQ-016 busy SHALL be 1 from edge N until edge N+14, and 0 in IDLE and DONE.
REQ-017 start while busy=1 SHALL be ignored with no side effects; bin_in changes during SHIFT SHALL NOT affect the result.
REQ-018 start accepted during the DONE cycle SHALL begin a new conversion, giving a throughput of one result per 15 cycles.
REQ-019 overflow SHALL be 1 exactly when the 5th BCD digit (ten-thousands) is non-zero.
REQ-020 bcd_out and overflow SHALL hold their value until the next completing edge; they SHALL NOT change during SHIFT.
REQ-021 Nibble arithmetic SHALL be 4-bit; after adjustment a nibble SHALL never exceed 9 at any completed step.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, busy=0, done=0, bcd_out=16'h0000, overflow=0, counter=0, and internal registers=0.
REQ-023 rst asserted mid-conversion SHALL abort the conversion with no done pulse; rst has priority over start on the same edge.

Configuration
REQ-024 Macro BCD_SATURATE_EN:
- Defined: when overflow=1, bcd_out SHALL be 16'h9999.
- Undefined: when overflow=1, bcd_out SHALL be the low four digits of the true result (16383 -> 16'h6383).
- overflow behaviour SHALL be identical in both builds.

Verification
REQ-025 bin_in=1000, start pulse -> done one cycle, 14 edges after acceptance; bcd_out=16'h1000; overflow=0; busy high for exactly 14 cycles.
REQ-026 bin_in=0 -> bcd_out=16'h0000; then bin_in=9999 -> bcd_out=16'h9999, overflow=0.
REQ-027 bin_in=16383 -> overflow=1; bcd_out=16'h9999 with BCD_SATURATE_EN, 16'h6383 without.
REQ-028 Accept 1234; at cycle 5 drive start=1 with bin_in=42 -> ignored; result 16'h1234; exactly one done pulse.
REQ-029 Accept 4321; assert rst at cycle 7 -> no done pulse, all outputs 0; a subsequent request for 0056 completes normally with bcd_out=16'h0056.
REQ-030 Back-to-back: start held high with bin_in=12 then 345 -> second request accepted in the DONE cycle; done pulses 15 cycles apart; results 16'h0012 then 16'h0345.
